// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port among NUM_REQ requesters
//
// Purpose: grants one requester at a time access to a single-beat memory
// port. The current owner is kept for up to MAX_BURST consecutive beats while
// it keeps requesting. After that, or when it drops its request, the next
// owner is picked round-robin. One dead cycle (TURN) is inserted whenever the
// bus direction flips between beats.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req[NUM_REQ]            per-requester request, held until its ack
//   rd_wr[NUM_REQ]          per-requester direction (0 read, 1 write)
//   tem_win[NUM_REQ]        per-requester format (0 template, 1 window)
//   row/col[NUM_REQ][7]     per-requester address
//   write_data[NUM_REQ][32] per-requester write word
//   ack[NUM_REQ]            one-cycle completion pulse to the owner
//   read_data[32]           mem_rdata broadcast, qualified by ack
//   grant[NUM_REQ]          registered one-hot owner, zero when none
//   mem_req/mem_rd_wr/mem_tem_win/mem_row/mem_col/mem_wdata  memory command
//   mem_ack, mem_rdata      memory completion pulse and read word
//   busy                    high whenever not IDLE
//   stray_ack               sticky: mem_ack seen outside XFER
module mem_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       rd_wr,
  input  logic [NUM_REQ-1:0]       tem_win,
  input  logic [NUM_REQ-1:0][6:0]  row,
  input  logic [NUM_REQ-1:0][6:0]  col,
  input  logic [NUM_REQ-1:0][31:0] write_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [31:0]              read_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     mem_req,
  output logic                     mem_rd_wr,
  output logic                     mem_tem_win,
  output logic [6:0]               mem_row,
  output logic [6:0]               mem_col,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     busy,
  output logic                     stray_ack
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;      // current owner, or last one when grant is zero
  logic [CW-1:0]   beat_cnt;
  logic            last_dir;   // direction of the last completed beat
  logic            dir_valid;  // no beat completed since reset: never turn around

  logic            keep_owner;
  logic            rr_found;
  logic [IW-1:0]   rr_idx;
  logic [IW-1:0]   cand_idx;
  int              cand;
  logic [IW-1:0]   next_owner;
  logic            need_turn;

  // The owner may continue only while it still holds a grant and is under
  // its burst allowance.
  always_comb begin
    keep_owner = (|grant) && req[owner] && (beat_cnt < BURST_MAX);
  end

  // Round-robin scan starting at owner+1; wraps back to owner itself last,
  // which is what lets a lone requester be re-granted after its burst.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = owner;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(owner) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IW'(cand);
      if (!rr_found && req[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    next_owner = keep_owner ? owner : rr_idx;
    need_turn  = dir_valid && (rd_wr[next_owner] != last_dir);
  end

  // Memory command is a pure decode of the registered state and owner.
  always_comb begin
    mem_req     = 1'b0;
    mem_rd_wr   = 1'b0;
    mem_tem_win = 1'b0;
    mem_row     = '0;
    mem_col     = '0;
    mem_wdata   = '0;
    ack         = '0;
    if (state == XFER) begin
      mem_req     = 1'b1;
      mem_rd_wr   = rd_wr[owner];
      mem_tem_win = tem_win[owner];
      mem_row     = row[owner];
      mem_col     = col[owner];
      mem_wdata   = write_data[owner];
      if (mem_ack) ack = grant;
    end
  end

  assign read_data = mem_rdata;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= LAST_IDX;
      beat_cnt  <= '0;
      last_dir  <= 1'b0;
      dir_valid <= 1'b0;
      stray_ack <= 1'b0;
    end else begin
      if (mem_ack && (state != XFER)) stray_ack <= 1'b1;
      case (state)
        IDLE: begin
          grant <= '0;
          if (|req) state <= ARB;
        end
        ARB: begin
          if (!(|req)) begin
            grant <= '0;
            state <= IDLE;
          end else begin
            grant <= NUM_REQ'(1) << next_owner;
            owner <= next_owner;
            if (!keep_owner) beat_cnt <= '0;
            state <= need_turn ? TURN : XFER;
          end
        end
        TURN: state <= XFER;
        XFER: begin
          if (mem_ack) begin
            if (beat_cnt != BURST_MAX) beat_cnt <= beat_cnt + CW'(1);
            last_dir  <= rd_wr[owner];
            dir_valid <= 1'b1;
            state     <= ARB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int MB = 4;
  localparam int P_IDLE = 0, P_ARB = 1, P_XFER = 2, P_TURN = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, rd_wr, tem_win;
  logic [N-1:0][6:0] row, col;
  logic [N-1:0][31:0] write_data;
  logic [N-1:0]      ack, grant;
  logic [31:0]       read_data, mem_wdata, mem_rdata;
  logic              mem_req, mem_rd_wr, mem_tem_win, mem_ack, busy, stray_ack;
  logic [6:0]        mem_row, mem_col;

  mem_port_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rd_wr(rd_wr), .tem_win(tem_win),
    .row(row), .col(col), .write_data(write_data), .ack(ack),
    .read_data(read_data), .grant(grant), .mem_req(mem_req),
    .mem_rd_wr(mem_rd_wr), .mem_tem_win(mem_tem_win), .mem_row(mem_row),
    .mem_col(mem_col), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .stray_ack(stray_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: phase, owner (-1 = none), burst usage, direction history.
  int m_phase, m_owner, m_last, m_cnt;
  bit m_dir, m_dir_valid, m_stray;

  function automatic int rr_pick(input logic [2:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (after + k) % N;
      if (r[2'(c)]) return c;
    end
    return after;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_owner = -1; m_last = N - 1; m_cnt = 0;
    m_dir = 1'b0; m_dir_valid = 1'b0; m_stray = 1'b0;
  endtask

  task automatic model_advance();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (mem_ack && m_phase != P_XFER) m_stray = 1'b1;
    case (m_phase)
      P_IDLE: if (req != 0) m_phase = P_ARB;
      P_ARB: begin
        if (req == 0) begin
          m_phase = P_IDLE;
          m_owner = -1;
        end else begin
          if (!(m_owner >= 0 && req[2'(m_owner)] && m_cnt < MB)) begin
            m_owner = rr_pick(req, m_last);
            m_cnt   = 0;
          end
          m_last  = m_owner;
          m_phase = (m_dir_valid && rd_wr[2'(m_owner)] != m_dir) ? P_TURN : P_XFER;
        end
      end
      P_TURN: m_phase = P_XFER;
      default: begin
        if (mem_ack) begin
          m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
          m_dir = rd_wr[2'(m_owner)];
          m_dir_valid = 1'b1;
          m_phase = P_ARB;
        end
      end
    endcase
  endtask

  task automatic model_compare();
    logic [2:0] eg = 3'b000;
    logic [1:0] oi;
    logic xf;
    oi = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    if (m_owner >= 0) eg = 3'b001 << oi;
    xf = (m_phase == P_XFER);
    check("busy", 64'(busy), 64'(m_phase != P_IDLE));
    check("grant", 64'(grant), 64'(eg));
    check("mem_req", 64'(mem_req), 64'(xf));
    check("ack", 64'(ack), 64'((xf && mem_ack) ? eg : 3'b000));
    check("read_data", 64'(read_data), 64'(mem_rdata));
    check("stray_ack", 64'(stray_ack), 64'(m_stray));
    check("mem_rd_wr", 64'(mem_rd_wr), 64'(xf ? rd_wr[oi] : 1'b0));
    check("mem_tem_win", 64'(mem_tem_win), 64'(xf ? tem_win[oi] : 1'b0));
    check("mem_row", 64'(mem_row), 64'(xf ? row[oi] : 7'd0));
    check("mem_col", 64'(mem_col), 64'(xf ? col[oi] : 7'd0));
    check("mem_wdata", 64'(mem_wdata), 64'(xf ? write_data[oi] : 32'd0));
  endtask

  // Memory responder, requester bookkeeping and logs
  int lat = 0;
  int wcnt = 0;
  bit stray_inject = 1'b0;
  logic [31:0] rd_base = 32'h0;
  int remaining [N];
  int ack_log[$];
  int ack_cyc[$];
  logic [31:0] ack_data[$];
  int turn_cnt = 0;
  bit prev_gap = 1'b0;
  logic [31:0] cap_wdata = 32'h0;

  task automatic step();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    cyc++;
    mem_ack = 1'b0;
    if (stray_inject) begin
      mem_ack = 1'b1;
      stray_inject = 1'b0;
    end else if (mem_req) begin
      if (wcnt >= lat) begin mem_ack = 1'b1; wcnt = 0; end
      else wcnt++;
    end else begin
      wcnt = 0;
    end
    mem_rdata = rd_base + 32'(ack_log.size());
    #2;
    model_compare();
    if (busy && !mem_req && prev_gap) turn_cnt++;
    prev_gap = busy && !mem_req;
    if (mem_req && grant[2]) cap_wdata = mem_wdata;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ack_log.push_back(i);
        ack_cyc.push_back(cyc);
        ack_data.push_back(read_data);
        if (remaining[i] > 0) remaining[i]--;
        if (remaining[i] == 0) req[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_logs();
    ack_log.delete(); ack_cyc.delete(); ack_data.delete();
    turn_cnt = 0; prev_gap = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    req = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    step();
    step();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 30) begin step(); g++; end
    check(name, 64'(busy), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    int mreq_cyc;
    int exp_order [4];
    exp_order = '{0, 1, 2, 0};
    req = '0; rd_wr = '0; tem_win = '0; row = '0; col = '0; write_data = '0;
    mem_ack = 1'b0; mem_rdata = '0; rst_n = 1'b0;
    row[1] = 7'd17; col[1] = 7'd33; row[2] = 7'd99; col[2] = 7'd127;
    tem_win[1] = 1'b1; write_data[0] = 32'hA0A0_0000; write_data[1] = 32'h1111_1111;

    // Reset state
    do_reset();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_grant", 64'(grant), 64'(0));
    check("reset_stray", 64'(stray_ack), 64'(0));

    // Single read, memory answers two cycles after mem_req
    lat = 2; rd_base = 32'h1234_5600;
    row[0] = 7'd3; col[0] = 7'd5; remaining[0] = 1; req[0] = 1'b1;
    g = 0;
    while (!mem_req && g < 10) begin step(); g++; end
    mreq_cyc = cyc;
    check("t035_mem_req", 64'(mem_req), 64'(1));
    check("t035_row", 64'(mem_row), 64'(3));
    check("t035_col", 64'(mem_col), 64'(5));
    g = 0;
    while (ack_log.size() < 1 && g < 10) begin step(); g++; end
    check("t035_ack_cnt", 64'(ack_log.size()), 64'(1));
    if (ack_log.size() >= 1) begin
      check("t035_ack_owner", 64'(ack_log[0]), 64'(0));
      check("t035_ack_data", 64'(ack_data[0]), 64'(32'h1234_5600));
      check("t035_ack_delay", 64'(ack_cyc[0] - mreq_cyc), 64'(2));
    end
    wait_idle("t035_idle");
    step(); step();
    check("t035_single_ack", 64'(ack_log.size()), 64'(1));

    // Three readers held high, MAX_BURST = 4
    do_reset();
    lat = 0;
    for (int i = 0; i < N; i++) remaining[i] = 100;
    req = 3'b111;
    g = 0;
    while (ack_log.size() < 16 && g < 100) begin step(); g++; end
    req = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    check("t036_ack_total", 64'(ack_log.size()), 64'(16));
    if (ack_log.size() >= 16)
      for (int j = 0; j < 16; j++) check("t036_owner", 64'(ack_log[j]), 64'(exp_order[j/4]));
    check("t036_turns", 64'(turn_cnt), 64'(0));
    wait_idle("t036_idle");

    // Read by 1 then write by 2, zero-wait memory
    do_reset();
    lat = 0; rd_wr[1] = 1'b0; rd_wr[2] = 1'b1; write_data[2] = 32'hCAFE_F00D;
    remaining[1] = 1; remaining[2] = 1; req = 3'b110;
    g = 0;
    while (ack_log.size() < 2 && g < 30) begin step(); g++; end
    check("t037_ack_total", 64'(ack_log.size()), 64'(2));
    if (ack_log.size() >= 2) begin
      check("t037_first", 64'(ack_log[0]), 64'(1));
      check("t037_second", 64'(ack_log[1]), 64'(2));
      check("t037_gap", 64'(ack_cyc[1] - ack_cyc[0]), 64'(3));
    end
    check("t037_turns", 64'(turn_cnt), 64'(1));
    check("t037_wdata", 64'(cap_wdata), 64'(32'hCAFE_F00D));
    wait_idle("t037_idle");

    // Lone requester past MAX_BURST keeps the port
    do_reset();
    lat = 0; rd_wr[0] = 1'b0; remaining[0] = 6; req = 3'b001;
    g = 0;
    while (ack_log.size() < 6 && g < 40) begin step(); g++; end
    check("lone_ack_total", 64'(ack_log.size()), 64'(6));
    if (ack_log.size() >= 6)
      for (int j = 1; j < 6; j++) begin
        check("lone_owner", 64'(ack_log[j]), 64'(0));
        check("lone_gap", 64'(ack_cyc[j] - ack_cyc[j-1]), 64'(2));
      end
    wait_idle("lone_idle");

    // Stray mem_ack while idle
    do_reset();
    step();
    stray_inject = 1'b1;
    step();
    check("t038_no_ack", 64'(ack), 64'(0));
    step();
    check("t038_stray_set", 64'(stray_ack), 64'(1));
    step(); step(); step();
    check("t038_stray_sticky", 64'(stray_ack), 64'(1));
    check("t038_ack_log", 64'(ack_log.size()), 64'(0));
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t038_stray_clear", 64'(stray_ack), 64'(0));
    step();
    rst_n = 1'b1;

    // Reset during requester 2's transfer
    do_reset();
    lat = 3; rd_wr[2] = 1'b1; remaining[2] = 99; req = 3'b100;
    g = 0;
    while (!(mem_req && grant == 3'b100) && g < 10) begin step(); g++; end
    check("t039_in_xfer", 64'(grant), 64'(3'b100));
    step();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t039_grant0", 64'(grant), 64'(0));
    check("t039_ack0", 64'(ack), 64'(0));
    check("t039_mem_req0", 64'(mem_req), 64'(0));
    check("t039_busy0", 64'(busy), 64'(0));
    check("t039_wdata0", 64'(mem_wdata), 64'(0));
    check("t039_row0", 64'(mem_row), 64'(0));
    check("t039_no_ack", 64'(ack_log.size()), 64'(0));
    req = 3'b110; rd_wr[1] = 1'b0; remaining[1] = 1; remaining[2] = 1;
    step();
    rst_n = 1'b1;
    g = 0;
    while (grant == 3'b000 && g < 10) begin step(); g++; end
    check("t039_first_grant", 64'(grant), 64'(3'b010));
    g = 0;
    while (ack_log.size() < 2 && g < 40) begin step(); g++; end
    check("t039_ack_total", 64'(ack_log.size()), 64'(2));
    if (ack_log.size() >= 2) begin
      check("t039_first_ack", 64'(ack_log[0]), 64'(1));
      check("t039_second_ack", 64'(ack_log[1]), 64'(2));
    end
    wait_idle("t039_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning the number of requesters (index 0 template reader, 1 window reader, 2 result writer).
REQ-002 The block SHALL have parameter MAX_BURST, default 16, meaning the maximum consecutive beats granted to one requester while others wait.
REQ-003 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  NUM_REQ  per-requester request; held with its command until its ack.
REQ-007 rd_wr  input  NUM_REQ  per-requester direction: 0 = read, 1 = write.
REQ-008 tem_win  input  NUM_REQ  per-requester format select: 0 = template, 1 = window.
REQ-009 row, col  input  NUM_REQ x 7 each  per-requester address.
REQ-010 write_data  input  NUM_REQ x 32  per-requester write word.
REQ-011 ack  output  NUM_REQ  one-cycle pulse marking completion of a requester's beat.
REQ-012 read_data  output  32  mem_rdata broadcast to all requesters; qualified by ack.
REQ-013 grant  output  NUM_REQ  one-hot registered grant; all zeros when no owner.
REQ-014 mem_req, mem_rd_wr, mem_tem_win  output  1 each  memory command.
REQ-015 mem_row, mem_col  output  7 each  memory address; mem_wdata  output  32  memory write word.
REQ-016 mem_ack  input  1  one-cycle pulse from memory: beat done, mem_rdata valid on reads.
REQ-017 mem_rdata  input  32  memory read word.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 stray_ack  output  1  sticky error flag.

Function
REQ-020 The FSM SHALL have states IDLE, ARB, XFER, TURN; all state, grant, beat counter, last-owner index and stray_ack registered.
REQ-021 IDLE: grant = 0 and mem_req = 0; any req bit high -> ARB next cycle.
REQ-022 ARB: mem_req = 0; pick the owner, load grant, then XFER, or TURN if the owner's rd_wr differs from the last completed beat's direction; no req high -> IDLE.
REQ-023 Owner selection: if the current owner still has req high and beat count < MAX_BURST, keep the owner; otherwise pick round-robin, first req high scanning from last_owner+1 modulo NUM_REQ.
REQ-024 A lone requester SHALL keep its grant past MAX_BURST: beat count resets to 0 and it is re-granted.
REQ-025 Beat count SHALL reset to 0 on every change of owner and saturate at MAX_BURST.
REQ-026 TURN: exactly one cycle with mem_req = 0, then XFER; the first beat after reset is never preceded by TURN.
REQ-027 XFER: mem_req = 1; mem_rd_wr, mem_tem_win, mem_row, mem_col and mem_wdata combinationally muxed from the granted requester.
REQ-028 On mem_ack in XFER: ack[owner] = 1 in the same cycle, read_data = mem_rdata, beat count +1, last direction updated, next state ARB.
REQ-029 Outside XFER, ack SHALL be 0 and memory command outputs 0; read_data is always mem_rdata.
REQ-030 A requester dropping req during XFER SHALL NOT abort the beat; the beat completes and the ack is still issued.
REQ-031 mem_ack in IDLE, ARB or TURN SHALL set stray_ack = 1, cleared only by reset, and produce no ack.
REQ-032 Minimum beat cost: ARB (1) + XFER (at least 1) cycles; zero-wait memory gives one beat per 2 cycles.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, grant = 0, ack = 0, mem_req = 0, busy = 0, stray_ack = 0, beat count = 0, last_owner = NUM_REQ-1, last direction = read.
REQ-034 Reset mid-XFER SHALL abandon the beat with no ack; after release, the first arbitration favours requester 0.

Verification
REQ-035 Req[0] read at row 3, col 5, memory acks 2 cycles after mem_req -> mem_row = 3, mem_col = 5, ack[0] pulses once with mem_rdata, then IDLE.
REQ-036 MAX_BURST = 4, all three req held high, reads -> grant order 0,1,2,0, exactly 4 acks each, no TURN cycles.
REQ-037 Req[1] read then req[2] write, zero-wait memory -> one TURN cycle (mem_req = 0) between the two beats; mem_wdata equals write_data[2].
REQ-038 mem_ack pulsed while IDLE -> stray_ack = 1 and stays 1, ack stays 0; cleared only by rst_n.
REQ-039 rst_n low during XFER of requester 2 -> all outputs zero asynchronously, no ack; after release with req = 3'b110 -> requester 1 granted first.
